// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int TIMEOUT_DEF    = 16;
  localparam int STARVE_MAX_DEF = 4;

  // Selects the 32-bit instruction within a 64-bit memory word.
  function automatic logic [31:0] fetch_word(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Busy-cycle counter for the arbiter; expired marks the last cycle an access may wait.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (run) cnt_d = cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments and an async reset in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory between the IF fetch port and the MEM data port.
// Optional MEM_ARB_FAIR_EN bounds fetch starvation to STARVE_MAX consecutive data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  if (TIMEOUT < 2 || STARVE_MAX < 1 || DATA_W < 64) begin : g_bad_param
    $error("mem_arbiter: need TIMEOUT >= 2, STARVE_MAX >= 1, DATA_W >= 64");
  end

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;
  logic              busy, grant, grant_own, expired;

  assign busy  = (state_q != IDLE);
  assign grant = (state_q == IDLE) && (if_req || d_req);

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          force_if;

  assign force_if  = if_req && d_req && (starve_q >= SW'(STARVE_MAX));
  assign grant_own = (d_req && !force_if) ? OWN_D : OWN_IF;

  // Counts data grants that left a fetch waiting; any fetch grant resets it.
  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (grant_own == OWN_IF)                          starve_d = '0;
      else if (if_req && starve_q < SW'(STARVE_MAX))    starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign grant_own = d_req ? OWN_D : OWN_IF;
`endif

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .run     (busy),
    .expired (expired)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          if (grant_own == OWN_D) begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            state_d = BUSY_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      BUSY_IF: begin
        if (m_ready) begin
          if_rdata_d = fetch_word(m_rdata[63:0], addr_q[2]);
          if_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (expired) begin
          if_rdata_d = '0;
          if_valid_d = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          if (!we_q) d_rdata_d = m_rdata;
          d_valid_d = 1'b1;
          state_d   = IDLE;
        end else if (expired) begin
          d_rdata_d = '0;
          d_valid_d = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
    end
  end

  assign m_req    = busy;
  assign m_we     = (state_q == BUSY_D) && we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign err      = err_q;
  assign if_stall = if_req && !if_valid_q;
  assign d_stall  = d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random-wait memory responder, per-port expectation queues.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int LIMIT      = 300;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req, if_valid, if_stall;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        err;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_ready(m_ready), .err(err)
  );

  int          checks = 0;
  int          errors = 0;
  int          wait_cfg;          // <0: random 0..3 wait cycles per access
  string       grant_log;
  logic [31:0] exp_if[$];
  logic [63:0] exp_d[$];
  logic [63:0] last_d;
  logic [63:0] model_mem[logic [63:0]];
  logic [63:0] resp_mem[logic [63:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] default_word(input logic [63:0] idx);
    return {idx[31:0] ^ 32'h5A5A_0F0F, ~idx[31:0]};
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] addr);
    logic [63:0] idx = addr >> 3;
    return model_mem.exists(idx) ? model_mem[idx] : default_word(idx);
  endfunction

  function automatic logic [63:0] resp_word(input logic [63:0] addr);
    logic [63:0] idx = addr >> 3;
    return resp_mem.exists(idx) ? resp_mem[idx] : default_word(idx);
  endfunction

  // Grant order implied by the priority rules when nd loads and ni fetches are all queued at once.
  function automatic string expected_grants(input int nd, input int ni);
    string s = "";
    int    starve = 0;
    while (nd > 0 || ni > 0) begin
      if (nd > 0 && !(FAIR && ni > 0 && starve >= STARVE_MAX)) begin
        s = {s, "D"};
        nd--;
        if (ni > 0) starve++;
      end else begin
        s = {s, "I"};
        ni--;
        starve = 0;
      end
    end
    return s;
  endfunction

  // Memory responder: acts on each busy cycle at the falling edge.
  initial begin
    bit          in_acc;
    logic [63:0] a_addr, a_wdata;
    logic        a_we;
    int          waits;
    in_acc  = 1'b0;
    waits   = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          a_addr  = m_addr;
          a_we    = m_we;
          a_wdata = m_wdata;
          waits   = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
          if (m_addr >= 64'h1000) grant_log = {grant_log, "D"};
          else                    grant_log = {grant_log, "I"};
        end else begin
          check("m_addr_stable", m_addr, a_addr);
          check("m_we_stable", m_we, a_we);
          check("m_wdata_stable", m_wdata, a_wdata);
        end
        if (waits == 0) begin
          m_ready = 1'b1;
          if (a_we) begin
            resp_mem[a_addr >> 3] = a_wdata;
            m_rdata = {$urandom, $urandom};
          end else begin
            m_rdata = resp_word(a_addr);
          end
          in_acc = 1'b0;
        end else begin
          waits--;
          m_ready = 1'b0;
          m_rdata = {$urandom, $urandom};
        end
      end else begin
        in_acc  = 1'b0;
        m_ready = 1'($urandom_range(0, 1));
        m_rdata = {$urandom, $urandom};
      end
    end
  end

  // Scoreboard monitor: every valid pulse must match the oldest expectation of its port.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid) begin
        if (exp_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected: if_valid with rdata 0x%0h, none expected", if_rdata);
        end else begin
          e = 64'(exp_if.pop_front());
          check("if_rdata", 64'(if_rdata), e);
        end
      end
      if (!rst && d_valid) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected: d_valid with rdata 0x%0h, none expected", d_rdata);
        end else begin
          e = exp_d.pop_front();
          check("d_rdata", d_rdata, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: run did not complete, %0d checks done", checks);
    $fatal(1, "tb_mem_arbiter stopped by global timeout");
  end

  // Drivers: called at posedge+2, return at posedge+2 of the valid cycle; lat counts cycles.
  task automatic fetch_txn(input logic [63:0] addr, output int lat);
    logic [63:0] w = model_word(addr);
    int c = 0;
    exp_if.push_back(addr[2] ? w[63:32] : w[31:0]);
    if_addr = addr;
    if_req  = 1'b1;
    do begin @(posedge clk); #2; c++; end while (!if_valid && c < LIMIT);
    check("if_done", if_valid, 1'b1);
    if_req = 1'b0;
    lat = c;
  endtask

  task automatic d_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input bit abort, output int lat);
    int c = 0;
    if (abort)    last_d = '0;
    else if (!we) last_d = model_word(addr);
    else          model_mem[addr >> 3] = wdata;
    exp_d.push_back(last_d);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    do begin @(posedge clk); #2; c++; end while (!d_valid && c < LIMIT);
    check("d_done", d_valid, 1'b1);
    d_req = 1'b0;
    lat = c;
  endtask

  initial begin
    int lat_a, lat_b;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; wait_cfg = 0; grant_log = ""; last_d = '0;
    model_mem[0] = 64'hAAAA_BBBB_1111_2222;
    resp_mem[0]  = 64'hAAAA_BBBB_1111_2222;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_req", m_req, 0);       check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);     check("rst_m_wdata", m_wdata, 0);
    check("rst_if_rdata", 64'(if_rdata), 0); check("rst_d_rdata", d_rdata, 0);
    check("rst_if_valid", if_valid, 0); check("rst_d_valid", d_valid, 0);
    check("rst_err", err, 0);
    #1 rst = 1'b0;

    // Fetch only, zero-wait memory: cycle-accurate handshake and stall.
    fork
      fetch_txn(64'h4, lat_a);
      begin
        #1;
        check("f_c0_stall", if_stall, 1); check("f_c0_m_req", m_req, 0);
        @(posedge clk); #1;
        check("f_c1_m_req", m_req, 1);    check("f_c1_m_addr", m_addr, 64'h4);
        check("f_c1_m_we", m_we, 0);      check("f_c1_stall", if_stall, 1);
        check("f_c1_valid", if_valid, 0);
        @(posedge clk); #1;
        check("f_c2_valid", if_valid, 1); check("f_c2_stall", if_stall, 0);
        check("f_c2_m_req", m_req, 0);
      end
    join
    check("f_latency", lat_a, 2);

    // Simultaneous requests: data first, fetch after one idle bubble.
    fork
      d_txn(1'b0, 64'h100, '0, 1'b0, lat_a);
      fetch_txn(64'h8, lat_b);
    join
    check("sim_d_latency", lat_a, 2);
    check("sim_if_latency", lat_b, 4);

    // Store with three memory wait cycles.
    wait_cfg = 3;
    fork
      d_txn(1'b1, 64'h20, 64'h55, 1'b0, lat_a);
      begin
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
          check("st_m_req", m_req, 1);     check("st_m_we", m_we, 1);
          check("st_m_addr", m_addr, 64'h20); check("st_m_wdata", m_wdata, 64'h55);
          check("st_stall", d_stall, 1);
          @(posedge clk); #1;
        end
        check("st_valid", d_valid, 1);
      end
    join
    check("st_latency", lat_a, 5);
    wait_cfg = 0;
    d_txn(1'b0, 64'h20, '0, 1'b0, lat_a);

    // Memory never answers: abort after TIMEOUT busy cycles, sticky err.
    check("err_before_timeout", err, 0);
    wait_cfg = 1000;
    d_txn(1'b0, 64'h1008, '0, 1'b1, lat_a);
    check("timeout_latency", lat_a, 17);
    check("err_after_timeout", err, 1);
    wait_cfg = 0;
    fetch_txn(64'h14, lat_a);
    check("err_sticky", err, 1);

    // Reset in the middle of a data access.
    wait_cfg = 10;
    d_we = 1'b0; d_addr = 64'h1010; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_m_req", m_req, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_m_req", m_req, 0);   check("rst_mid_err", err, 0);
    check("rst_mid_d_valid", d_valid, 0); check("rst_mid_if_rdata", 64'(if_rdata), 0);
    d_req = 1'b0; last_d = '0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 wait_cfg = 0;
    d_txn(1'b0, 64'h1010, '0, 1'b0, lat_a);
    check("post_rst_latency", lat_a, 2);

    // Both ports requesting continuously: grant order.
    grant_log = "";
    fork
      begin
        int l;
        for (int k = 0; k < 10; k++) d_txn(1'b0, 64'h1000 + 64'(8 * k), '0, 1'b0, l);
      end
      begin
        int l;
        for (int k = 0; k < 2; k++) fetch_txn(64'h100 + 64'(4 * k), l);
      end
    join
    checks++;
    if (grant_log != expected_grants(10, 2)) begin
      errors++;
      $display("FAIL grant_order: got %s expected %s", grant_log, expected_grants(10, 2));
    end

    // Random traffic on both ports with random memory waits.
    wait_cfg = -1;
    fork
      begin
        int l;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
          d_txn(1'($urandom_range(0, 1)), 64'h1000 + 64'(8 * $urandom_range(0, 15)),
                {$urandom, $urandom}, 1'b0, l);
        end
      end
      begin
        int l;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
          fetch_txn(64'(4 * $urandom_range(0, 63)), l);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("final_err", err, 0);
    check("if_queue_empty", 64'(exp_if.size()), 0);
    check("d_queue_empty", 64'(exp_d.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
